spi_conf_rx: RTL and testbench

// Synchronous replacement for the SPI configuration receiver that feeds the

---
 rtl/spi_conf_rx_if.sv | 35 +++
 rtl/spi_conf_rx.sv | 152 +++++++++++++++
 tb/tb_spi_conf_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_conf_rx_if.sv
// -----------------------------------------------------------------------------
// spi_conf_rx_if
// Bundles the ARM-side SPI pins and the decoded configuration registers that
// feed the major-mode muxes.
//   spck, mosi, ncs   : SPI pins from the ARM (asynchronous to the FPGA clock)
//   conf_word         : FPGA_CMD_SET_CONFREG payload
//   major_mode        : conf_word[7:5]
//   divisor           : FPGA_CMD_SET_DIVISOR payload
//   conf_enio         : FPGA_CMD_SET_ENIOCONFREG payload
//   cmd_strobe        : one-cycle pulse on any register write
//   frame_err         : one-cycle pulse on a frame of the wrong length
// modport master : the side that drives SPI and observes the registers
// modport slave  : the receiver itself
// -----------------------------------------------------------------------------
interface spi_conf_rx_if;
    logic       spck;
    logic       mosi;
    logic       ncs;
    logic [7:0] conf_word;
    logic [2:0] major_mode;
    logic [7:0] divisor;
    logic [7:0] conf_enio;
    logic       cmd_strobe;
    logic       frame_err;

    modport master (
        output spck, mosi, ncs,
        input  conf_word, major_mode, divisor, conf_enio, cmd_strobe, frame_err
    );

    modport slave (
        input  spck, mosi, ncs,
        output conf_word, major_mode, divisor, conf_enio, cmd_strobe, frame_err
    );
endinterface

// File: rtl/spi_conf_rx.sv
// -----------------------------------------------------------------------------
// spi_conf_rx
// Synchronous SPI configuration receiver. Samples spck/mosi/ncs in the
// ck_1356meg domain, deserialises WORD_BITS-bit command frames (MSB first) and,
// on the rising edge of chip select, decodes the opcode into one of three
// configuration registers. Each register changes in a single clock cycle so
// downstream mode logic never sees a partial update.
// Ports:
//   ck_1356meg : system clock, all logic on posedge
//   reset      : asynchronous, active-high reset
//   bus        : spi_conf_rx_if.slave (SPI pins in, registers and pulses out)
// -----------------------------------------------------------------------------
module spi_conf_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 16
) (
    input  logic          ck_1356meg,
    input  logic          reset,
    spi_conf_rx_if.slave  bus
);

    localparam logic [3:0] OP_SET_CONFREG     = 4'b0001;
    localparam logic [3:0] OP_SET_DIVISOR     = 4'b0010;
    localparam logic [3:0] OP_SET_ENIOCONFREG = 4'b0100;
    localparam logic [4:0] FRAME_LEN          = 5'(WORD_BITS);
    localparam logic [7:0] CONF_WORD_RST      = 8'hE0;

    // Synchroniser chains; the last stage is the usable synchronous copy.
    logic [SYNC_STAGES-1:0] spck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   spck_d;
    logic                   ncs_d;

    logic spck_s, mosi_s, ncs_s;
    logic spck_rise, ncs_fall, ncs_rise, shift_en;

    logic [WORD_BITS-1:0] shift_reg;
    logic [4:0]           bit_cnt;

    logic [7:0] conf_word_q, divisor_q, conf_enio_q;
    logic [7:0] conf_word_nxt, divisor_nxt, conf_enio_nxt;
    logic       cmd_strobe_q, frame_err_q;
    logic       cmd_strobe_nxt, frame_err_nxt;

    logic [3:0] opcode;
    logic [7:0] payload;

    // NOTE: ncs flops reset to 1 (idle), not 0, so releasing reset with the
    // bus idle never fabricates an ncs rise and a spurious frame end.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            spck_sync <= '0;
            mosi_sync <= '0;
            ncs_sync  <= '1;
            spck_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            spck_sync <= {spck_sync[SYNC_STAGES-2:0], bus.spck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.ncs};
            spck_d    <= spck_s;
            ncs_d     <= ncs_s;
        end
    end

    assign spck_s    = spck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign spck_rise = spck_s & ~spck_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    // A spck rise coinciding with the ncs rise sees ncs_s high and is dropped.
    assign shift_en  = spck_rise & ~ncs_s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            if (shift_en) begin
                shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_s};
            end
            if (ncs_fall) begin
                // A bit landing on the select edge itself still counts.
                bit_cnt <= shift_en ? 5'd1 : 5'd0;
            end else if (shift_en && bit_cnt != 5'd31) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    assign opcode  = shift_reg[WORD_BITS-1 -: 4];
    assign payload = shift_reg[7:0];

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        conf_word_nxt  = conf_word_q;
        divisor_nxt    = divisor_q;
        conf_enio_nxt  = conf_enio_q;
        cmd_strobe_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        if (ncs_rise) begin
            if (bit_cnt == FRAME_LEN) begin
                unique case (opcode)
                    OP_SET_CONFREG: begin
                        conf_word_nxt  = payload;
                        cmd_strobe_nxt = 1'b1;
                    end
                    OP_SET_DIVISOR: begin
                        divisor_nxt    = payload;
                        cmd_strobe_nxt = 1'b1;
                    end
                    OP_SET_ENIOCONFREG: begin
                        conf_enio_nxt  = payload;
                        cmd_strobe_nxt = 1'b1;
                    end
                    default: ; // unknown opcodes are silently ignored
                endcase
            end else begin
                frame_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            conf_word_q  <= CONF_WORD_RST;
            divisor_q    <= '0;
            conf_enio_q  <= '0;
            cmd_strobe_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            conf_word_q  <= conf_word_nxt;
            divisor_q    <= divisor_nxt;
            conf_enio_q  <= conf_enio_nxt;
            cmd_strobe_q <= cmd_strobe_nxt;
            frame_err_q  <= frame_err_nxt;
        end
    end

    assign bus.conf_word  = conf_word_q;
    assign bus.major_mode = conf_word_q[7:5];
    assign bus.divisor    = divisor_q;
    assign bus.conf_enio  = conf_enio_q;
    assign bus.cmd_strobe = cmd_strobe_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_conf_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_conf_rx
// Directed bench for spi_conf_rx. A frame-level model predicts register
// contents and the cycle of each strobe from the bits sent; a negedge process
// compares every output against it each cycle, and literal expectations after
// each scenario pin the model.
// -----------------------------------------------------------------------------
module tb_spi_conf_rx;

    localparam int SYNC_STAGES = 2;
    localparam int WORD_BITS   = 16;
    localparam int HALF_SPCK   = 4;   // spck = clk/8

    typedef enum int { EV_NONE, EV_WRITE, EV_ERR } ev_kind_e;
    typedef enum int { R_CONF, R_DIV, R_ENIO } reg_sel_e;

    logic clk;
    logic rst;
    spi_conf_rx_if bus();

    spi_conf_rx #(.SYNC_STAGES(SYNC_STAGES), .WORD_BITS(WORD_BITS)) dut (
        .ck_1356meg (clk),
        .reset      (rst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Frame model state
    logic [7:0] exp_conf = 8'hE0;
    logic [7:0] exp_div  = 8'h00;
    logic [7:0] exp_enio = 8'h00;
    logic       pend_valid = 1'b0;
    int         pend_cycle = 0;
    ev_kind_e   pend_kind  = EV_NONE;
    reg_sel_e   pend_sel   = R_CONF;
    logic [7:0] pend_val   = 8'h00;
    int         frame_cnt  = 0;
    logic [15:0] frame_word = 16'h0;

    // Observed pulse history for literal checks
    int strobe_cnt = 0;
    int err_cnt    = 0;
    int last_strobe_cyc = 0;
    int ncs_rise_cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic es, ee;
        es = 1'b0;
        ee = 1'b0;
        if (pend_valid && cyc == pend_cycle) begin
            pend_valid = 1'b0;
            if (pend_kind == EV_WRITE) begin
                es = 1'b1;
                case (pend_sel)
                    R_CONF:  exp_conf = pend_val;
                    R_DIV:   exp_div  = pend_val;
                    default: exp_enio = pend_val;
                endcase
            end else if (pend_kind == EV_ERR) begin
                ee = 1'b1;
            end
        end
        check("conf_word",  bus.conf_word,  exp_conf);
        check("major_mode", bus.major_mode, exp_conf[7:5]);
        check("divisor",    bus.divisor,    exp_div);
        check("conf_enio",  bus.conf_enio,  exp_enio);
        check("cmd_strobe", bus.cmd_strobe, es);
        check("frame_err",  bus.frame_err,  ee);
        if (bus.cmd_strobe === 1'b1) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_begin();
        bus.ncs   = 1'b0;
        frame_cnt = 0;
        wait_cycles(HALF_SPCK);
    endtask

    task automatic send_bit(input logic b);
        bus.mosi = b;
        bus.spck = 1'b0;
        wait_cycles(HALF_SPCK);
        bus.spck = 1'b1;
        wait_cycles(HALF_SPCK);
        frame_cnt++;
        frame_word = {frame_word[14:0], b};
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Raise ncs and schedule what the frame must do: outputs move on the
    // (SYNC_STAGES+1)th edge after the edge that first sees ncs high.
    task automatic frame_end();
        bus.spck = 1'b0;
        wait_cycles(HALF_SPCK);
        bus.ncs      = 1'b1;
        ncs_rise_cyc = cyc;
        pend_kind    = EV_NONE;
        pend_val     = frame_word[7:0];
        if (frame_cnt != WORD_BITS) begin
            pend_kind = EV_ERR;
        end else begin
            case (frame_word[15:12])
                4'b0001: begin pend_kind = EV_WRITE; pend_sel = R_CONF; end
                4'b0010: begin pend_kind = EV_WRITE; pend_sel = R_DIV;  end
                4'b0100: begin pend_kind = EV_WRITE; pend_sel = R_ENIO; end
                default: pend_kind = EV_NONE;
            endcase
        end
        pend_cycle = cyc + SYNC_STAGES + 1;
        pend_valid = 1'b1;
        wait_cycles(8);
    endtask

    task automatic send_frame(input logic [31:0] w, input int n);
        frame_begin();
        send_bits(w, n);
        frame_end();
    endtask

    initial begin
        rst      = 1'b1;
        bus.spck = 1'b0;
        bus.mosi = 1'b0;
        bus.ncs  = 1'b1;
        wait_cycles(4);

        // 1. reset state
        check("rst conf_word",  bus.conf_word, 8'hE0);
        check("rst major_mode", bus.major_mode, 3'b111);
        rst = 1'b0;
        wait_cycles(4);
        check("idle strobes", strobe_cnt + err_cnt, 0);

        // 2. set conf register
        send_frame(32'h106A, 16);
        check("t2 conf_word",  bus.conf_word, 8'h6A);
        check("t2 major_mode", bus.major_mode, 3'b011);
        check("t2 strobes",    strobe_cnt, 1);
        check("t2 latency",    last_strobe_cyc - ncs_rise_cyc, 3);

        // 3. divisor then enio
        send_frame(32'h205F, 16);
        send_frame(32'h40C3, 16);
        check("t3 divisor",   bus.divisor, 8'h5F);
        check("t3 conf_enio", bus.conf_enio, 8'hC3);
        check("t3 conf_word", bus.conf_word, 8'h6A);
        check("t3 strobes",   strobe_cnt, 3);

        // 4. short, long and empty frames
        send_frame(32'h1011, 15);
        send_frame(32'h1_1033, 17);
        send_frame(32'h0, 0);
        check("t4 errs",      err_cnt, 3);
        check("t4 strobes",   strobe_cnt, 3);
        check("t4 conf_word", bus.conf_word, 8'h6A);
        check("t4 divisor",   bus.divisor, 8'h5F);
        check("t4 conf_enio", bus.conf_enio, 8'hC3);

        // 5. unknown opcode
        send_frame(32'h80FF, 16);
        check("t5 strobes", strobe_cnt, 3);
        check("t5 errs",    err_cnt, 3);
        check("t5 regs",    {bus.conf_word, bus.divisor, bus.conf_enio}, 24'h6A5FC3);

        // 6. reset mid-frame, then a clean frame
        frame_begin();
        send_bits(32'h10AA >> 7, 9);
        rst        = 1'b1;
        pend_valid = 1'b0;
        exp_conf   = 8'hE0;
        exp_div    = 8'h00;
        exp_enio   = 8'h00;
        bus.ncs    = 1'b1;
        bus.spck   = 1'b0;
        wait_cycles(3);
        check("t6 rst conf_word", bus.conf_word, 8'hE0);
        rst = 1'b0;
        wait_cycles(8);
        check("t6 aborted conf_word", bus.conf_word, 8'hE0);
        check("t6 aborted strobes",   strobe_cnt, 3);
        send_frame(32'h1022, 16);
        check("t6 conf_word", bus.conf_word, 8'h22);
        check("t6 strobes",   strobe_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
